condlogic: RTL
==============

CONDLOGIC -- requirements
Module: condlogic

Interface
REQ-001 The block SHALL have these ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; reset asserted while low.
REQ-003 Cond  input  4  condition field, Instr[31:28], stable while the instruction register holds.
REQ-004 ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-005 FlagW  input  2  from decode; [1] requests an N,Z update, [0] requests a C,V update.
REQ-006 PCS  input  1  from decode; PC is a destination (branch, or a write to R15).
REQ-007 NextPC  input  1  from the main FSM; unconditional PC increment (fetch cycle).
REQ-008 RegW  input  1  from the main FSM; register-file write request.
REQ-009 MemW  input  1  from the main FSM; data-memory write request.
REQ-010 PCWrite, RegWrite, MemWrite  output  1 each  gated write enables to the datapath.
REQ-011 Flags  output  4  registered {N,Z,C,V}, for debug and bench observation.
REQ-012 CondExOut  output  1  registered condition-pass bit (CondExDelayed).

Function
REQ-013 The block SHALL compute CondEx combinationally from Cond and the registered Flags: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never, 0.
REQ-014 FlagWrite[1:0] SHALL be FlagW & {2{CondEx}}, using the undelayed CondEx.
REQ-015 Flags[3:2] SHALL load ALUFlags[3:2] on a clock edge with FlagWrite[1]=1 and hold otherwise.
REQ-016 Flags[1:0] SHALL load ALUFlags[1:0] on a clock edge with FlagWrite[0]=1 and hold otherwise.
REQ-017 CondExDelayed SHALL register CondEx on every clock edge, giving a latency of one cycle.
REQ-018 RegWrite SHALL equal RegW & CondExDelayed.
REQ-019 MemWrite SHALL equal MemW & CondExDelayed.
REQ-020 PCWrite SHALL equal (PCS & CondExDelayed) | NextPC.
REQ-021 NextPC SHALL force PCWrite=1 regardless of condition, Cond=1111 included.
REQ-022 CondEx SHALL be evaluated against the flags held before the edge; a flag update and a read in the same cycle SHALL NOT forward the new value.
REQ-023 A failed condition SHALL suppress the flag update, the register write, the memory write and the PC write for that instruction, but SHALL NOT suppress NextPC.
REQ-024 All outputs SHALL be glitch-free functions of registered state plus the FSM strobes; no combinational path SHALL run from ALUFlags to any output.

Reset
REQ-025 While reset is low, Flags SHALL be 4'b0000 and CondExDelayed SHALL be 0, asynchronously.
REQ-026 While reset is low, RegWrite=0 and MemWrite=0, and PCWrite SHALL equal NextPC.
REQ-027 Reset deasserted mid-instruction SHALL leave the flags at zero and CondExDelayed at 0 until the first rising edge.

Structure
REQ-028 Condition-code encodings (EQ..AL, NV) and flag bit indices SHALL live in a shared header cond_defs.vh, reused by decode and the bench.
REQ-029 The condition evaluation SHALL be a separate purely combinational sub-module named condcheck (Cond, Flags -> CondEx).
REQ-030 The registers SHALL be three enable flops (2-bit NZ, 2-bit CV, 1-bit CondEx), each with asynchronous active-low clear.

Verification
REQ-031 Reset low, Cond=1110, RegW=1, NextPC=1 -> Flags=0000, RegWrite=0, PCWrite=1.
REQ-032 After reset, Cond=1110, FlagW=11, ALUFlags=0100, one edge -> Flags=0100; then Cond=0000, RegW=1 one cycle later -> RegWrite=1.
REQ-033 Flags=0100, Cond=0001 (NE), FlagW=11, ALUFlags=1000 -> Flags stay 0100; next cycle MemW=1 -> MemWrite=0, PCS=1 -> PCWrite=0.
REQ-034 Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100 (C,V preserved); then FlagW=01, ALUFlags=0011 -> Flags=1111.
REQ-035 Sweep all 16 Cond values against all 16 Flags values -> CondExOut after one edge matches the REQ-013 table; Cond=1111 always gives 0.
REQ-036 Reset pulsed low for 1 ns between edges while Flags=1010 -> Flags=0000 and CondExOut=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/condlogic_pkg.sv
// rtl/condlogic_pkg.sv - condition-code encodings and flag bit indices
//
// Shared by condcheck, condlogic and the bench so every user agrees on the
// meaning of Instr[31:28] and on where N, Z, C and V sit in a flag nibble.

package condlogic_pkg;

  // Flag bit positions inside a {N,Z,C,V} nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bit positions coming from decode.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  // Condition field encodings.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/condlogic_condcheck.sv
// rtl/condlogic_condcheck.sv - purely combinational condition evaluator
//
// Ports:
//   Cond   in  [3:0]  condition field of the current instruction
//   Flags  in  [3:0]  registered {N,Z,C,V}
//   CondEx out        1 when the instruction's condition passes

module condcheck (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);
  import condlogic_pkg::*;

  logic n, z, c, v;
  logic ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// rtl/condlogic.sv - conditional-execution unit of the multicycle controller
//
// Holds the architectural NZCV flags, evaluates the current instruction's
// condition against them and gates the FSM's write strobes.
//
// Ports:
//   clk        in        rising-edge clock
//   reset      in        asynchronous active-low clear
//   Cond       in  [3:0] Instr[31:28]
//   ALUFlags   in  [3:0] {N,Z,C,V} produced by the ALU this cycle
//   FlagW      in  [1:0] [1] NZ update request, [0] CV update request
//   PCS        in        PC is a destination of this instruction
//   NextPC     in        unconditional PC increment (fetch)
//   RegW       in        register-file write request
//   MemW       in        data-memory write request
//   PCWrite    out       gated PC write enable
//   RegWrite   out       gated register-file write enable
//   MemWrite   out       gated data-memory write enable
//   Flags      out [3:0] registered {N,Z,C,V}
//   CondExOut  out       registered condition-pass bit

module condlogic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondExOut
);
  import condlogic_pkg::*;

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       cond_ex;
  logic       cond_ex_q;
  logic [1:0] flag_write;

  assign Flags = {nz_q, cv_q};

  // Evaluated against the flags held before the edge, so a flag update in
  // the same cycle never feeds back into this instruction's own condition.
  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  // A failed condition suppresses the flag update of this instruction.
  assign flag_write = FlagW & {2{cond_ex}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      nz_q <= 2'b00;
    else if (flag_write[FLAGW_NZ])
      nz_q <= ALUFlags[FLAG_N:FLAG_Z];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cv_q <= 2'b00;
    else if (flag_write[FLAGW_CV])
      cv_q <= ALUFlags[FLAG_C:FLAG_V];
  end

  // Write strobes arrive one FSM state after decode, so the pass bit is
  // delayed by one cycle to line up with them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cond_ex_q <= 1'b0;
    else
      cond_ex_q <= cond_ex;
  end

  assign CondExOut = cond_ex_q;

  // Only registered state and FSM strobes reach the outputs; NextPC is
  // never gated so fetch proceeds even for a never-executed instruction.
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign PCWrite  = (PCS & cond_ex_q) | NextPC;

endmodule
